// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the MAC feeder: FSM states, phase lengths,
// index sizing and fixed-point constants.
package mac_feeder_pkg;

    localparam int S_DEF        = 8;
    localparam int N_DEF        = 32;
    localparam int INTBITS_DEF  = 12;
    localparam int FRACBITS_DEF = 20;

    localparam int CLR_CYC   = 1;
    localparam int PRIME_CYC = 2;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        PRIME  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        RESULT = 3'd5
    } state_t;

    // Wide enough to hold a fill count of 0..S inclusive.
    function automatic int idx_width(input int s);
        return $clog2(s + 1);
    endfunction

    localparam logic [N_DEF-1:0] FX_ONE  = N_DEF'(1) << FRACBITS_DEF;
    localparam logic [N_DEF-1:0] FX_ZERO = '0;

endpackage

// File: rtl/mac_feeder_if.sv
// Host/MAC-facing bus of the MAC feeder. The slave modport is the feeder side,
// the master modport is the host and MAC side.
interface mac_feeder_if
    import mac_feeder_pkg::*;
#(
    parameter int N = N_DEF
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid, once raised, holds its payload until that edge.
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_w;
    logic [N-1:0] load_x;
    logic         start;
    logic         busy;
    logic         mac_rst;
    logic [N-1:0] mac_w;
    logic [N-1:0] mac_x;
    logic [N-1:0] mac_sum;
    logic [N-1:0] result;
    logic         result_valid;
    logic         result_ready;

    modport slave (
        input  load_valid, load_w, load_x, start, mac_sum, result_ready,
        output load_ready, busy, mac_rst, mac_w, mac_x, result, result_valid
    );

    modport master (
        output load_valid, load_w, load_x, start, mac_sum, result_ready,
        input  load_ready, busy, mac_rst, mac_w, mac_x, result, result_valid
    );

endinterface

// File: rtl/mac_feeder_pair_buffer.sv
// S-entry weight/input register file with a fill counter, one write port and
// one registered, zero-padding read port.
module mac_feeder_pair_buffer
    import mac_feeder_pkg::*;
#(
    parameter int S = S_DEF,
    parameter int N = N_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [N-1:0]            i_wr_w,
    input  logic [N-1:0]            i_wr_x,
    input  logic                    i_clear,
    input  logic                    i_rd_en,
    input  logic [idx_width(S)-1:0] i_rd_idx,
    output logic [idx_width(S)-1:0] o_count,
    output logic [N-1:0]            o_rd_w,
    output logic [N-1:0]            o_rd_x
);
    localparam int CW = idx_width(S);
    localparam int AW = (S > 1) ? $clog2(S) : 1;

    logic [N-1:0]  r_mem_w [S];
    logic [N-1:0]  r_mem_x [S];
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_rd_w;
    logic [N-1:0]  r_rd_x;

    // Storage is deliberately not reset; the fill count masks stale slots.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem_w[r_count[AW-1:0]] <= i_wr_w;
            r_mem_x[r_count[AW-1:0]] <= i_wr_x;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_wr_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_w <= '0;
            r_rd_x <= '0;
        end else if (i_rd_en && (i_rd_idx < r_count)) begin
            r_rd_w <= r_mem_w[i_rd_idx[AW-1:0]];
            r_rd_x <= r_mem_x[i_rd_idx[AW-1:0]];
        end else begin
            r_rd_w <= '0;
            r_rd_x <= '0;
        end
    end

    assign o_count = r_count;
    assign o_rd_w  = r_rd_w;
    assign o_rd_x  = r_rd_x;

endmodule

// File: rtl/mac_feeder.sv
// Sequencer that resets the MAC, streams the buffered pairs onto its W/X inputs
// in step with the MAC's internal counter, and hands back the captured sum.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int S = S_DEF,
    parameter int N = N_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mac_feeder_if.slave bus,
    output state_t      o_state
);
    localparam int CW = idx_width(S);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mac_rst;
    logic [N-1:0]  r_result;
    logic          r_result_valid;

    logic          w_load_ready;
    logic          w_load_fire;
    logic          w_clear;
    logic          w_rd_en;
    logic [CW-1:0] w_rd_idx;
    logic [CW-1:0] w_count;
    logic [N-1:0]  w_rd_w;
    logic [N-1:0]  w_rd_x;

    assign w_load_ready = reset && (r_state == IDLE) && (w_count < CW'(S));
    assign w_load_fire  = bus.load_valid && w_load_ready;
    assign w_clear      = (r_state == RESULT) && bus.result_ready;

    // The read port is registered, so the address runs one cycle ahead of the
    // slot that appears on mac_w/mac_x.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_idx = '0;
        if ((r_state == PRIME) && (r_cnt == CW'(PRIME_CYC - 1))) begin
            w_rd_en = 1'b1;
        end else if ((r_state == STREAM) && (r_cnt != CW'(S - 1))) begin
            w_rd_en  = 1'b1;
            w_rd_idx = r_cnt + 1'b1;
        end
    end

    mac_feeder_pair_buffer #(
        .S(S),
        .N(N)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (w_load_fire),
        .i_wr_w   (bus.load_w),
        .i_wr_x   (bus.load_x),
        .i_clear  (w_clear),
        .i_rd_en  (w_rd_en),
        .i_rd_idx (w_rd_idx),
        .o_count  (w_count),
        .o_rd_w   (w_rd_w),
        .o_rd_x   (w_rd_x)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_mac_rst      <= 1'b1;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mac_rst <= 1'b0;
                    if (bus.start) begin
                        r_state   <= CLR;
                        r_cnt     <= '0;
                        r_mac_rst <= 1'b1;
                    end
                end
                CLR: begin
                    if (r_cnt == CW'(CLR_CYC - 1)) begin
                        r_state   <= PRIME;
                        r_cnt     <= '0;
                        r_mac_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRIME: begin
                    if (r_cnt == CW'(PRIME_CYC - 1)) begin
                        r_state <= STREAM;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (r_cnt == CW'(S - 1)) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // The MAC latched its sum one edge ago; it is stable now.
                    if (r_cnt == CW'(DRAIN_CYC - 1)) begin
                        r_state        <= RESULT;
                        r_cnt          <= '0;
                        r_result       <= bus.mac_sum;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.result_ready) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_cnt          <= '0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready   = w_load_ready;
    assign bus.busy         = (r_state != IDLE);
    assign bus.mac_rst      = r_mac_rst;
    assign bus.mac_w        = w_rd_w;
    assign bus.mac_x        = w_rd_x;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign o_state          = r_state;

endmodule
